// File: rtl/friscv_pkg.sv
// Shared FRiscV definitions used by the front-end PC sequencing logic.
package friscv_pkg;

  localparam int unsigned XLEN         = 32;
  localparam int unsigned FLUSH_CYCLES = 2;

  // Numeric order of the codes doubles as redirect priority (trap highest).
  typedef enum logic [1:0] {
    PC_PLUS4  = 2'b00,
    PC_BRANCH = 2'b01,
    PC_JALR   = 2'b10,
    PC_TRAP   = 2'b11
  } pc_src_e;

  typedef enum logic [2:0] {
    RESET_S,
    RUN,
    STALL,
    PEND,
    FLUSH
  } pc_ctrl_state_e;

endpackage

// File: rtl/pc_ctrl_redirect_arb.sv
// Fixed-priority redirect select: trap > jalr > branch.
module redirect_arb #(
  parameter int unsigned XLEN = 32
) (
  input  logic                     trap_req,
  input  logic                     jalr_req,
  input  logic                     branch_req,
  input  logic [XLEN-1:0]          trap_tgt,
  input  logic [XLEN-1:0]          jalr_tgt,
  input  logic [XLEN-1:0]          branch_tgt,
  output logic                     valid,
  output friscv_pkg::pc_src_e      code,
  output logic [XLEN-1:0]          target
);
  import friscv_pkg::*;

  // Highest-priority active request wins; the rest are dropped.
  always_comb begin
    valid  = 1'b0;
    code   = PC_PLUS4;
    target = '0;
    if (trap_req) begin
      valid  = 1'b1;
      code   = PC_TRAP;
      target = trap_tgt;
    end else if (jalr_req) begin
      valid  = 1'b1;
      code   = PC_JALR;
      target = jalr_tgt;
    end else if (branch_req) begin
      valid  = 1'b1;
      code   = PC_BRANCH;
      target = branch_tgt;
    end
  end

endmodule

// File: rtl/pc_ctrl.sv
// Next-PC sequencer and front-end hazard controller.
module pc_ctrl #(
  parameter int unsigned XLEN         = friscv_pkg::XLEN,
  parameter int unsigned FLUSH_CYCLES = friscv_pkg::FLUSH_CYCLES
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            imem_ready_in,
  input  logic            hazard_stall_in,
  input  logic            branch_taken_in,
  input  logic            jalr_in,
  input  logic            trap_in,
  input  logic [XLEN-1:0] branch_tgt_in,
  input  logic [XLEN-1:0] jalr_tgt_in,
  input  logic [XLEN-1:0] trap_vec_in,
  output logic [1:0]      pc_src_out,
  output logic [XLEN-1:0] target_out,
  output logic            pc_en_out,
  output logic            stall_if_id_out,
  output logic            flush_if_id_out,
  output logic            flush_id_ex_out,
  output logic            fetch_valid_out
);
  import friscv_pkg::*;

  localparam logic [1:0]     CNT_LOAD   = 2'(FLUSH_CYCLES - 1);
  localparam pc_ctrl_state_e POST_REDIR = (FLUSH_CYCLES > 1) ? FLUSH : RUN;

  pc_ctrl_state_e  state;
  logic [1:0]      cnt;
  pc_src_e         pend_code;
  logic [XLEN-1:0] pend_tgt;
  logic [XLEN-1:0] target_q;

  logic            req_valid;
  pc_src_e         req_code;
  logic [XLEN-1:0] req_tgt;

  logic            pend_take;
  pc_src_e         go_code;
  logic [XLEN-1:0] go_tgt;
  logic            go;

  redirect_arb #(.XLEN(XLEN)) u_arb (
    .trap_req   (trap_in),
    .jalr_req   (jalr_in),
    .branch_req (branch_taken_in),
    .trap_tgt   (trap_vec_in),
    .jalr_tgt   (jalr_tgt_in),
    .branch_tgt (branch_tgt_in),
    .valid      (req_valid),
    .code       (req_code),
    .target     (req_tgt)
  );

  // Redirect selection: live request outside PEND, pending (possibly overwritten) inside PEND.
  always_comb begin
    pend_take = req_valid && ((req_code == PC_TRAP) || (req_code > pend_code));
    go        = 1'b0;
    go_code   = PC_PLUS4;
    go_tgt    = target_q;
    if (state == PEND) begin
      // A same-cycle higher-priority request is applied rather than lost.
      go      = imem_ready_in;
      go_code = pend_take ? req_code : pend_code;
      go_tgt  = pend_take ? req_tgt  : pend_tgt;
    end else if (state != RESET_S) begin
      go      = req_valid && imem_ready_in;
      go_code = req_code;
      go_tgt  = req_tgt;
    end
  end

  // Combinational front-end controls from state, requests and imem readiness.
  always_comb begin
    pc_src_out      = PC_PLUS4;
    target_out      = target_q;
    pc_en_out       = 1'b0;
    stall_if_id_out = 1'b0;
    flush_if_id_out = 1'b0;
    flush_id_ex_out = 1'b0;
    fetch_valid_out = 1'b0;
    if (go) begin
      pc_src_out      = go_code;
      target_out      = go_tgt;
      pc_en_out       = 1'b1;
      flush_if_id_out = 1'b1;
      flush_id_ex_out = 1'b1;
    end else begin
      case (state)
        RESET_S, PEND: begin
          flush_if_id_out = 1'b1;
          flush_id_ex_out = 1'b1;
        end
        default: begin
          if (req_valid) begin
            flush_if_id_out = 1'b1;
            flush_id_ex_out = 1'b1;
          end else if (state == FLUSH) begin
            flush_if_id_out = 1'b1;
            pc_en_out       = imem_ready_in;
          end else if (!imem_ready_in) begin
            stall_if_id_out = 1'b1;
            flush_id_ex_out = hazard_stall_in;
          end else if (hazard_stall_in) begin
            stall_if_id_out = 1'b1;
            flush_id_ex_out = 1'b1;
          end else begin
            pc_en_out       = 1'b1;
            fetch_valid_out = 1'b1;
          end
        end
      endcase
    end
  end

  // State, flush counter, pending redirect and last applied target.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= RESET_S;
      cnt       <= '0;
      pend_code <= PC_PLUS4;
      pend_tgt  <= '0;
      target_q  <= '0;
    end else begin
      if (go) begin
        target_q <= go_tgt;
      end
      case (state)
        RESET_S: state <= RUN;
        PEND: begin
          if (imem_ready_in) begin
            pend_code <= PC_PLUS4;
            pend_tgt  <= '0;
            cnt       <= CNT_LOAD;
            state     <= POST_REDIR;
          end else if (pend_take) begin
            pend_code <= req_code;
            pend_tgt  <= req_tgt;
          end
        end
        RUN, STALL, FLUSH: begin
          if (req_valid) begin
            if (imem_ready_in) begin
              cnt   <= CNT_LOAD;
              state <= POST_REDIR;
            end else begin
              pend_code <= req_code;
              pend_tgt  <= req_tgt;
              state     <= PEND;
            end
          end else if (state == FLUSH) begin
            if (imem_ready_in) begin
              if (cnt <= 2'd1) begin
                cnt   <= '0;
                state <= RUN;
              end else begin
                cnt <= cnt - 2'd1;
              end
            end
          end else if (imem_ready_in) begin
            state <= hazard_stall_in ? STALL : RUN;
          end
        end
        default: state <= RESET_S;
      endcase
    end
  end

endmodule

// File: tb/tb_pc_ctrl.sv
// Self-checking bench for pc_ctrl: vector table through a scoreboard queue,
// plus a hand-written flush-length sequence.
module tb_pc_ctrl;

  logic        clk = 1'b0;
  logic        rst, imem_ready_in, hazard_stall_in, branch_taken_in, jalr_in, trap_in;
  logic [31:0] branch_tgt_in, jalr_tgt_in, trap_vec_in;
  logic [1:0]  pc_src_out;
  logic [31:0] target_out;
  logic        pc_en_out, stall_if_id_out, flush_if_id_out, flush_id_ex_out, fetch_valid_out;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pc_ctrl #(.XLEN(32), .FLUSH_CYCLES(2)) dut (
    .clk             (clk),
    .rst             (rst),
    .imem_ready_in   (imem_ready_in),
    .hazard_stall_in (hazard_stall_in),
    .branch_taken_in (branch_taken_in),
    .jalr_in         (jalr_in),
    .trap_in         (trap_in),
    .branch_tgt_in   (branch_tgt_in),
    .jalr_tgt_in     (jalr_tgt_in),
    .trap_vec_in     (trap_vec_in),
    .pc_src_out      (pc_src_out),
    .target_out      (target_out),
    .pc_en_out       (pc_en_out),
    .stall_if_id_out (stall_if_id_out),
    .flush_if_id_out (flush_if_id_out),
    .flush_id_ex_out (flush_id_ex_out),
    .fetch_valid_out (fetch_valid_out)
  );

  // in: {rst, ready, hazard, branch, jalr, trap}; outs: {src[1:0], en, stall, flush_if, flush_ex, fetch_valid}
  typedef struct {
    logic [5:0]  in;
    logic [31:0] bt, jt, tv;
    logic [6:0]  outs;
    logic [31:0] tgt;
    logic        ctgt;
  } vec_t;

  localparam logic [5:0] I_RST  = 6'b110000, I_RSTN = 6'b100000, I_IDLE = 6'b010000;
  localparam logic [5:0] I_NRDY = 6'b000000, I_HZ   = 6'b011000, I_HZBR = 6'b011100;
  localparam logic [5:0] I_BR   = 6'b010100, I_BRN  = 6'b000100, I_JR   = 6'b010010;
  localparam logic [5:0] I_JRN  = 6'b000010, I_TRN  = 6'b000001, I_ALL  = 6'b010111;

  localparam logic [6:0] O_RST = 7'b00_0_0_1_1_0, O_PND = 7'b00_0_0_1_1_0;
  localparam logic [6:0] O_RUN = 7'b00_1_0_0_0_1, O_STL = 7'b00_0_1_0_1_0;
  localparam logic [6:0] O_NRD = 7'b00_0_1_0_0_0, O_FL1 = 7'b00_1_0_1_0_0;
  localparam logic [6:0] O_FL0 = 7'b00_0_0_1_0_0, O_BR  = 7'b01_1_0_1_1_0;
  localparam logic [6:0] O_JR  = 7'b10_1_0_1_1_0, O_TR  = 7'b11_1_0_1_1_0;

  function automatic vec_t mk(input logic [5:0] in, input logic [31:0] bt, input logic [31:0] jt,
                              input logic [31:0] tv, input logic [6:0] outs,
                              input logic [31:0] tgt, input logic ctgt);
    vec_t v;
    v.in = in; v.bt = bt; v.jt = jt; v.tv = tv;
    v.outs = outs; v.tgt = tgt; v.ctgt = ctgt;
    return v;
  endfunction

  vec_t tbl[$];
  vec_t sb[$];

  task automatic check(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s vec%0d: got %h expected %h", name, idx, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    {rst, imem_ready_in, hazard_stall_in, branch_taken_in, jalr_in, trap_in} = v.in;
    branch_tgt_in = v.bt;
    jalr_tgt_in   = v.jt;
    trap_vec_in   = v.tv;
  endtask

  initial begin
    vec_t e;
    int   nflush;
    bit   done;

    // Reset held 3 cycles, then RESET_S for one cycle, then sequential fetch.
    tbl.push_back(mk(I_RST,  0, 0, 0, O_RST, 32'h0, 1'b1));
    tbl.push_back(mk(I_RST,  0, 0, 0, O_RST, 32'h0, 1'b1));
    tbl.push_back(mk(I_RST,  0, 0, 0, O_RST, 32'h0, 1'b1));
    tbl.push_back(mk(I_IDLE, 0, 0, 0, O_RST, 32'h0, 1'b1));
    tbl.push_back(mk(I_IDLE, 0, 0, 0, O_RUN, 32'h0, 1'b0));
    tbl.push_back(mk(I_IDLE, 0, 0, 0, O_RUN, 32'h0, 1'b0));
    // All three requests: trap wins, two flush cycles.
    tbl.push_back(mk(I_ALL, 32'h10, 32'h20, 32'h100, O_TR, 32'h100, 1'b1));
    tbl.push_back(mk(I_IDLE, 0, 0, 0, O_FL1, 32'h100, 1'b1));
    tbl.push_back(mk(I_IDLE, 0, 0, 0, O_RUN, 32'h0, 1'b0));
    // Branch while imem not ready for 3 cycles.
    tbl.push_back(mk(I_BRN,  32'h40, 0, 0, O_PND, 32'h100, 1'b1));
    tbl.push_back(mk(I_NRDY, 0, 0, 0, O_PND, 32'h100, 1'b1));
    tbl.push_back(mk(I_NRDY, 0, 0, 0, O_PND, 32'h100, 1'b1));
    tbl.push_back(mk(I_IDLE, 0, 0, 0, O_BR,  32'h40, 1'b1));
    tbl.push_back(mk(I_IDLE, 0, 0, 0, O_FL1, 32'h40, 1'b1));
    tbl.push_back(mk(I_IDLE, 0, 0, 0, O_RUN, 32'h0, 1'b0));
    // Pending branch overwritten by jalr; a later branch is ignored.
    tbl.push_back(mk(I_BRN,  32'h44, 0, 0, O_PND, 32'h40, 1'b1));
    tbl.push_back(mk(I_JRN,  0, 32'h80, 0, O_PND, 32'h40, 1'b1));
    tbl.push_back(mk(I_BRN,  32'h48, 0, 0, O_PND, 32'h40, 1'b1));
    tbl.push_back(mk(I_IDLE, 0, 0, 0, O_JR,  32'h80, 1'b1));
    tbl.push_back(mk(I_NRDY, 0, 0, 0, O_FL0, 32'h80, 1'b1));
    tbl.push_back(mk(I_IDLE, 0, 0, 0, O_FL1, 32'h80, 1'b1));
    tbl.push_back(mk(I_IDLE, 0, 0, 0, O_RUN, 32'h0, 1'b0));
    // Load-use stall, then stall overridden by a branch.
    tbl.push_back(mk(I_HZ,   0, 0, 0, O_STL, 32'h80, 1'b1));
    tbl.push_back(mk(I_HZ,   0, 0, 0, O_STL, 32'h80, 1'b1));
    tbl.push_back(mk(I_IDLE, 0, 0, 0, O_RUN, 32'h0, 1'b0));
    tbl.push_back(mk(I_HZ,   0, 0, 0, O_STL, 32'h80, 1'b1));
    tbl.push_back(mk(I_HZBR, 32'h60, 0, 0, O_BR, 32'h60, 1'b1));
    tbl.push_back(mk(I_IDLE, 0, 0, 0, O_FL1, 32'h60, 1'b1));
    tbl.push_back(mk(I_IDLE, 0, 0, 0, O_RUN, 32'h0, 1'b0));
    // imem not ready, no redirect.
    tbl.push_back(mk(I_NRDY, 0, 0, 0, O_NRD, 32'h60, 1'b1));
    tbl.push_back(mk(I_IDLE, 0, 0, 0, O_RUN, 32'h0, 1'b0));
    // Reset while pending: nothing applied afterwards, target cleared.
    tbl.push_back(mk(I_JRN,  0, 32'h90, 0, O_PND, 32'h60, 1'b1));
    tbl.push_back(mk(I_RSTN, 0, 0, 0, O_PND, 32'h60, 1'b1));
    tbl.push_back(mk(I_IDLE, 0, 0, 0, O_RST, 32'h0, 1'b1));
    tbl.push_back(mk(I_IDLE, 0, 0, 0, O_RUN, 32'h0, 1'b0));
    tbl.push_back(mk(I_IDLE, 0, 0, 0, O_RUN, 32'h0, 1'b1));
    // Trap overwrites pending trap; jalr cannot displace it.
    tbl.push_back(mk(I_TRN,  0, 0, 32'h100, O_PND, 32'h0, 1'b1));
    tbl.push_back(mk(I_TRN,  0, 0, 32'h200, O_PND, 32'h0, 1'b1));
    tbl.push_back(mk(I_JRN,  0, 32'h84, 0, O_PND, 32'h0, 1'b1));
    tbl.push_back(mk(I_IDLE, 0, 0, 0, O_TR,  32'h200, 1'b1));
    tbl.push_back(mk(I_IDLE, 0, 0, 0, O_FL1, 32'h200, 1'b1));
    tbl.push_back(mk(I_IDLE, 0, 0, 0, O_RUN, 32'h0, 1'b0));
    // Redirect arriving during FLUSH restarts the flush.
    tbl.push_back(mk(I_BR,   32'h70, 0, 0, O_BR, 32'h70, 1'b1));
    tbl.push_back(mk(I_JR,   0, 32'hA0, 0, O_JR, 32'hA0, 1'b1));
    tbl.push_back(mk(I_IDLE, 0, 0, 0, O_FL1, 32'hA0, 1'b1));
    tbl.push_back(mk(I_IDLE, 0, 0, 0, O_RUN, 32'h0, 1'b0));

    drive(mk(I_RST, 0, 0, 0, 7'd0, 0, 1'b0));
    repeat (2) @(posedge clk);
    #1;
    for (int i = 0; i < tbl.size(); i++) begin
      drive(tbl[i]);
      sb.push_back(tbl[i]);
      @(negedge clk);
      e = sb.pop_front();
      check("outs", i, 32'({pc_src_out, pc_en_out, stall_if_id_out, flush_if_id_out,
                            flush_id_ex_out, fetch_valid_out}), 32'(e.outs));
      if (e.ctgt) check("target", i, target_out, e.tgt);
      @(posedge clk);
      #1;
    end

    // Count flush_if_id cycles after a branch, bounded.
    drive(mk(I_BR, 32'h30, 0, 0, 7'd0, 0, 1'b0));
    nflush = 0;
    done   = 1'b0;
    @(negedge clk);
    if (flush_if_id_out) nflush++;
    @(posedge clk);
    #1;
    drive(mk(I_IDLE, 0, 0, 0, 7'd0, 0, 1'b0));
    for (int k = 0; k < 8 && !done; k++) begin
      @(negedge clk);
      if (flush_if_id_out) nflush++;
      else done = 1'b1;
      @(posedge clk);
      #1;
    end
    check("flush_len", 99, 32'(nflush), 32'd2);
    @(negedge clk);
    check("run_after_flush", 100, {30'd0, pc_en_out, fetch_valid_out}, 32'd3);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pc_ctrl.md
Name: pc_ctrl

Overview:
Next-PC sequencer and front-end hazard controller for the pipelined FRiscV core. It arbitrates between redirect requesters (trap, jalr, branch/jal from EX) and sequential fetch, drives the 2-bit pc_src select and target for the pc register, and gates pc advance on instruction-memory readiness and load-use stalls. It also generates IF/ID and ID/EX flush/stall controls, and holds a redirect pending when instruction memory cannot accept it.

Parameters:
XLEN, 32, datapath/address width (from friscv_pkg).
FLUSH_CYCLES, 2, bubble cycles asserted on flush_if_id_out after a redirect is applied; legal range 1..3.

Ports:
clk  in  1  core clock
rst  in  1  synchronous, active-high reset
imem_ready_in  in  1  instruction memory accepts a fetch this cycle
hazard_stall_in  in  1  load-use stall request from decode
branch_taken_in  in  1  EX resolved a taken branch/jal
jalr_in  in  1  EX resolved a jalr
trap_in  in  1  exception/ecall redirect request
branch_tgt_in  in  XLEN  branch/jal target
jalr_tgt_in  in  XLEN  jalr target; bit 0 already cleared upstream
trap_vec_in  in  XLEN  trap vector
pc_src_out  out  2  00 PC+4, 01 branch, 10 jalr, 11 trap
target_out  out  XLEN  redirect target for pc register
pc_en_out  out  1  pc register update enable
stall_if_id_out  out  1  hold IF/ID register
flush_if_id_out  out  1  bubble IF/ID
flush_id_ex_out  out  1  bubble ID/EX
fetch_valid_out  out  1  current fetch is architecturally valid

Behaviour:
- Reset (rst=1 at posedge): state=RESET_S, pending cleared, flush counter=0. Outputs during/after reset until first RUN cycle: pc_src_out=00, target_out=0, pc_en_out=0, stall_if_id_out=0, flush_if_id_out=1, flush_id_ex_out=1, fetch_valid_out=0.
- FSM states: RESET_S, RUN, STALL, PEND, FLUSH.
- RESET_S -> RUN unconditionally the cycle after rst deasserts.
- Redirect priority, same cycle: trap > jalr > branch. Lower-priority requests are dropped, not queued.
- RUN, no redirect, no stall, imem_ready_in=1: pc_src_out=00, pc_en_out=1, fetch_valid_out=1.
- RUN, hazard_stall_in=1, no redirect: pc_en_out=0, stall_if_id_out=1, flush_id_ex_out=1. Enter STALL; remain while hazard_stall_in=1. Return to RUN on deassert.
- RUN/STALL, imem_ready_in=0, no redirect: pc_en_out=0, stall_if_id_out=1, fetch_valid_out=0. No state change.
- Redirect with imem_ready_in=1 (any of RUN/STALL/FLUSH):
  - Combinationally: pc_src_out=code, target_out=selected target, pc_en_out=1, flush_if_id_out=1, flush_id_ex_out=1.
  - Load counter with FLUSH_CYCLES-1 and go to FLUSH, or go to RUN if FLUSH_CYCLES=1.
  - Redirect overrides hazard_stall_in.
- Redirect with imem_ready_in=0:
  - Register pending {code, target} and enter PEND. pc_en_out=0, both flushes=1.
- PEND:
  - pc_en_out=0 and flushes=1 while imem_ready_in=0.
  - On imem_ready_in=1: apply pending (pc_src_out/target_out from register, pc_en_out=1), clear pending, then FLUSH.
  - A new higher-priority request in PEND overwrites pending. Equal or lower priority is ignored.
  - trap_in always overwrites.
- FLUSH:
  - flush_if_id_out=1, fetch_valid_out=0, pc_en_out=imem_ready_in, pc_src_out=00.
  - Counter decrements only when imem_ready_in=1. Exit to RUN when it reaches 0 with imem_ready_in=1.
- Mid-operation reset: rst=1 in any state discards pending and counter on that edge. No redirect is applied.
- target_out in non-redirect cycles holds its last value. It is don't-care for pc_src_out=00.

Decomposition:
- friscv_pkg additions:
  - pc_src_e enum (PC_PLUS4=2'b00, PC_BRANCH=2'b01, PC_JALR=2'b10, PC_TRAP=2'b11), shared with pc.
  - pc_ctrl_state_e enum.
  - FLUSH_CYCLES default constant.
- One sub-module, redirect_arb: combinational priority select of {valid, code, target}, reusable by pending-overwrite logic.
- FSM and counter live in pc_ctrl.

Test Plan:
- Release rst after 3 cycles, imem_ready_in=1 -> RESET_S for 1 cycle (pc_en_out=0, fetch_valid_out=0), then pc_en_out=1, pc_src_out=00 every cycle.
- trap_in, jalr_in and branch_taken_in all asserted in one cycle with trap_vec_in=32'h0000_0100 -> pc_src_out=11, target_out=32'h100, flush_if_id_out high for exactly 2 cycles (FLUSH_CYCLES=2).
- branch_taken_in with branch_tgt_in=32'h40 while imem_ready_in=0 for 3 cycles -> pc_en_out=0 for 3 cycles, then pc_src_out=01, target_out=32'h40, pc_en_out=1 on the ready cycle.
- In PEND with a branch pending, assert jalr_in with jalr_tgt_in=32'h80, then ready -> applied pc_src_out=10, target_out=32'h80.
- hazard_stall_in high 2 cycles -> stall_if_id_out=1 and flush_id_ex_out=1 for 2 cycles, pc_en_out=0. A branch_taken_in during cycle 2 -> pc_en_out=1, pc_src_out=01 that cycle.
- Assert rst while in PEND -> next cycle pending cleared, pc_en_out=0, no redirect applied after release.
